// File: rtl/md_sched_pkg.sv
// Shared multiply/divide constants: operation codes, default latencies and the
// decode term that tells the scheduler a D-stage instruction touches HI/LO.
package md_sched_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   localparam int unsigned MD_MULT_CYCLES_DEF = 32'd5;
   localparam int unsigned MD_DIV_CYCLES_DEF  = 32'd10;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MTHI    = 6'h11;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MTLO    = 6'h13;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1A;
   localparam logic [5:0] FN_DIVU    = 6'h1B;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // Decode term for D_mduse; decode and the scheduler must agree on it.
   function automatic logic md_use_decode(input logic [5:0] opcode, input logic [5:0] funct);
      logic use_s;
      use_s = 1'b0;
      if (opcode == OP_SPECIAL) begin
         case (funct)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: use_s = 1'b1;
            default:                            use_s = 1'b0;
         endcase
      end else begin
         use_s = 1'b0;
      end
      return use_s;
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the 64-bit HI/LO result
// and a divide-by-zero flag; the scheduler decides when it is committed.
module md_arith
   import md_sched_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] res_hi_o,
   output logic [31:0] res_lo_o,
   output logic        div0_o
);

   logic [63:0] prod_s;
   logic [63:0] produ_s;
   logic        signed_div_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic [31:0] b_nz_s;
   logic [31:0] q_mag_s;
   logic [31:0] r_mag_s;
   logic [31:0] q_s;
   logic [31:0] r_s;

   assign prod_s  = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
   assign produ_s = {32'd0, a_i} * {32'd0, b_i};

   // Divide on magnitudes so truncation toward zero holds for every operand,
   // then restore signs: quotient by sign mismatch, remainder by dividend.
   always_comb begin
      signed_div_s = (op_i == MD_DIV);
      a_mag_s = (signed_div_s && a_i[31]) ? ((~a_i) + 32'd1) : a_i;
      b_mag_s = (signed_div_s && b_i[31]) ? ((~b_i) + 32'd1) : b_i;
      b_nz_s  = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
      q_mag_s = a_mag_s / b_nz_s;
      r_mag_s = a_mag_s % b_nz_s;
      q_s = (signed_div_s && (a_i[31] ^ b_i[31])) ? ((~q_mag_s) + 32'd1) : q_mag_s;
      r_s = (signed_div_s && a_i[31]) ? ((~r_mag_s) + 32'd1) : r_mag_s;
   end

   // Select the result for the requested operation.
   always_comb begin
      res_hi_o = 32'd0;
      res_lo_o = 32'd0;
      div0_o   = 1'b0;
      case (op_i)
         MD_MULT: begin
            res_hi_o = prod_s[63:32];
            res_lo_o = prod_s[31:0];
         end
         MD_MULTU: begin
            res_hi_o = produ_s[63:32];
            res_lo_o = produ_s[31:0];
         end
         MD_DIV, MD_DIVU: begin
            res_hi_o = r_s;
            res_lo_o = q_s;
            div0_o   = (b_i == 32'd0);
         end
         default: begin
            res_hi_o = 32'd0;
            res_lo_o = 32'd0;
            div0_o   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: models fixed latency with a countdown, owns HI/LO
// and raises the decode-stage stall for instructions that touch HI/LO.
module md_sched
   import md_sched_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        E_start,
   input  logic [2:0]  E_mdop,
   input  logic [31:0] E_a,
   input  logic [31:0] E_b,
   input  logic        D_mduse,
   output logic        busy,
   output logic        D_mdstall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = $clog2(MAX_CYC + 1);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        pend_hi_q, pend_hi_d;
   logic [31:0]        pend_lo_q, pend_lo_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic               busy_q, busy_d;

   logic [31:0]        res_hi_s;
   logic [31:0]        res_lo_s;
   logic               div0_s;

   md_arith u_arith (
      .op_i     (E_mdop),
      .a_i      (E_a),
      .b_i      (E_b),
      .res_hi_o (res_hi_s),
      .res_lo_o (res_lo_s),
      .div0_o   (div0_s)
   );

   // Next-state logic. A zero divisor latches the current HI/LO as the pending
   // result, so the commit after DIV_CYCLES leaves them unchanged.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (E_start) begin
               case (E_mdop)
                  MD_MULT, MD_MULTU: begin
                     pend_hi_d = res_hi_s;
                     pend_lo_d = res_lo_s;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     state_d   = ST_RUN;
                  end
                  MD_DIV, MD_DIVU: begin
                     pend_hi_d = div0_s ? hi_q : res_hi_s;
                     pend_lo_d = div0_s ? lo_q : res_lo_s;
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     state_d   = ST_RUN;
                  end
                  MD_MTHI: hi_d = E_a;
                  MD_MTLO: lo_d = E_a;
                  default: state_d = ST_IDLE;
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
   end

   // State, counter, pending result and committed HI/LO registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign D_mdstall = D_mduse & (E_start | busy_q);

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: table of arithmetic vectors plus hand-written
// sequences for stall timing, mthi/mtlo, back-to-back starts and reset abort.
module tb_md_sched;
   import md_sched_pkg::*;

   logic        clk;
   logic        reset;
   logic        E_start;
   logic [2:0]  E_mdop;
   logic [31:0] E_a;
   logic [31:0] E_b;
   logic        D_mduse;
   logic        busy;
   logic        D_mdstall;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      int          cyc;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[9];

   md_sched dut (
      .clk       (clk),
      .reset     (reset),
      .E_start   (E_start),
      .E_mdop    (E_mdop),
      .E_a       (E_a),
      .E_b       (E_b),
      .D_mduse   (D_mduse),
      .busy      (busy),
      .D_mdstall (D_mdstall),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A start while busy must never be driven; the stall exists to prevent it.
   always @(negedge clk) begin
      if (!reset && E_start && busy) begin
         errors++;
         $display("FAIL illegal_start: E_start=1 while busy=1 at %0t", $time);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and count the busy cycles that follow (bounded).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
      E_start = 1'b1;
      E_mdop  = op;
      E_a     = a;
      E_b     = b;
      tick();
      E_start = 1'b0;
      E_mdop  = MD_NONE;
      n = 0;
      while (busy && n < 64) begin
         n++;
         tick();
      end
   endtask

   initial begin
      int n;
      E_start = 1'b0;
      E_mdop  = MD_NONE;
      E_a     = 32'd0;
      E_b     = 32'd0;
      D_mduse = 1'b0;
      reset   = 1'b1;

      vecs[0] = '{MD_MULT,  32'hFFFFFFFF, 32'd2,        32'd0,  32'd0,  5,  32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'd0,  32'd0,  5,  32'h00000001, 32'hFFFFFFFE};
      vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'd0,  32'd0,  10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{MD_DIVU,  32'd7,        32'd2,        32'd0,  32'd0,  10, 32'h00000001, 32'h00000003};
      vecs[4] = '{MD_DIVU,  32'd7,        32'd0,        32'h11, 32'h22, 10, 32'h00000011, 32'h00000022};
      vecs[5] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd0,  32'd0,  10, 32'h00000001, 32'hFFFFFFFD};
      vecs[6] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'd5,  32'd6,  5,  32'h00000001, 32'h00000000};
      vecs[7] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'd0,  32'd0,  5,  32'h40000000, 32'h00000000};
      vecs[8] = '{MD_DIV,   32'd5,        32'd0,        32'hAAAA, 32'hBBBB, 10, 32'h0000AAAA, 32'h0000BBBB};

      // Reset state.
      repeat (3) tick();
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      reset = 1'b0;
      tick();
      D_mduse = 1'b1;
      #1;
      chk("idle_no_stall", {31'd0, D_mdstall}, 32'd0);
      D_mduse = 1'b0;

      // Table-driven arithmetic and latency.
      for (int i = 0; i < 9; i++) begin
         run_op(MD_MTHI, vecs[i].pre_hi, 32'd0, n);
         run_op(MD_MTLO, vecs[i].pre_lo, 32'd0, n);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
         chk($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
         chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
         chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      end

      // mult in E with mflo held in D: six stall cycles, then lo holds the product.
      D_mduse = 1'b1;
      E_start = 1'b1;
      E_mdop  = MD_MULT;
      E_a     = 32'd3;
      E_b     = 32'd5;
      #1;
      n = 0;
      while (D_mdstall && n < 64) begin
         n++;
         tick();
         E_start = 1'b0;
         E_mdop  = MD_NONE;
      end
      chk("mult_stall_cycles", 32'(n), 32'd6);
      chk("mult_stall_lo", lo, 32'd15);
      chk("mult_stall_busy", {31'd0, busy}, 32'd0);

      // A non-MD instruction in D never stalls, even during a multiply.
      D_mduse = 1'b0;
      E_start = 1'b1;
      E_mdop  = MD_MULT;
      E_a     = 32'd4;
      E_b     = 32'd4;
      #1;
      n = 0;
      for (int c = 0; c < 7; c++) begin
         if (D_mdstall) n++;
         tick();
         E_start = 1'b0;
         E_mdop  = MD_NONE;
      end
      chk("nonmd_stall_cycles", 32'(n), 32'd0);
      chk("nonmd_lo", lo, 32'd16);

      // mthi with mfhi in D: stall only in the start cycle, value visible next edge.
      D_mduse = 1'b1;
      E_start = 1'b1;
      E_mdop  = MD_MTHI;
      E_a     = 32'hDEADBEEF;
      #1;
      chk("mthi_stall_start", {31'd0, D_mdstall}, 32'd1);
      tick();
      E_start = 1'b0;
      E_mdop  = MD_NONE;
      #1;
      chk("mthi_stall_after", {31'd0, D_mdstall}, 32'd0);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      chk("mthi_hi", hi, 32'hDEADBEEF);
      D_mduse = 1'b0;

      // Unknown opcode: no state change.
      run_op(3'd7, 32'h12345678, 32'h9, n);
      chk("unk_cycles", 32'(n), 32'd0);
      chk("unk_hi", hi, 32'hDEADBEEF);
      chk("unk_lo", lo, 32'd16);

      // Back-to-back: second start in the first IDLE cycle after completion.
      run_op(MD_MULTU, 32'd6, 32'd7, n);
      run_op(MD_MULTU, 32'd9, 32'd9, n);
      chk("b2b_cycles", 32'(n), 32'd5);
      chk("b2b_lo", lo, 32'd81);
      chk("b2b_hi", hi, 32'd0);

      // Reset during the third busy cycle of a divide aborts it with no commit.
      run_op(MD_MTHI, 32'h55, 32'd0, n);
      E_start = 1'b1;
      E_mdop  = MD_DIVU;
      E_a     = 32'd100;
      E_b     = 32'd7;
      tick();
      E_start = 1'b0;
      E_mdop  = MD_NONE;
      tick();
      tick();
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      tick();
      reset = 1'b0;
      repeat (15) tick();
      chk("abort_no_commit_busy", {31'd0, busy}, 32'd0);
      chk("abort_no_commit_hi", hi, 32'd0);
      chk("abort_no_commit_lo", lo, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
